// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: legacy control levels,
// arbiter state encodings and the default watchdog limit.
package mem_bus_arbiter_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ChipEnable  = 1'b1;

  localparam logic [2:0] ARB_IDLE      = 3'd0;
  localparam logic [2:0] ARB_DATA_BUSY = 3'd1;
  localparam logic [2:0] ARB_INST_BUSY = 3'd2;
  localparam logic [2:0] ARB_DATA_DONE = 3'd3;
  localparam logic [2:0] ARB_INST_DONE = 3'd4;
  localparam logic [2:0] ARB_DISCARD   = 3'd5;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles and flags the cycle in which the
// TIMEOUT_CYCLES-th busy cycle completes without an ack.
module arb_watchdog #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and the MEM-stage
// data port, with registered bus signals, stall requests, flush and watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              stallreq_if_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_mem_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);

  logic [2:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              flushed_q, flushed_d;
  logic              wd_clr, wd_en, wd_expired;
  logic              flush_pend;

  arb_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // A flush seen at any point of a fetch (including its ack cycle) drops it
  assign flush_pend = flushed_q | flush_i;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = 1'b0;
    flushed_d   = flushed_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        flushed_d = 1'b0;
        if (!flush_i && mem_ce_i) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          wd_clr      = 1'b1;
          state_d     = ARB_DATA_BUSY;
        end else if (!flush_i && if_ce_i) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'b1111;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          wd_clr      = 1'b1;
          state_d     = ARB_INST_BUSY;
        end
      end
      ARB_DATA_BUSY: begin
        wd_en = 1'b1;
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_rdata_d = bus_rdata_i;
          state_d   = ARB_DATA_DONE;
        end else if (wd_expired) begin
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          mem_rdata_d = '0;
          state_d     = ARB_DATA_DONE;
        end
      end
      ARB_INST_BUSY: begin
        wd_en     = 1'b1;
        flushed_d = flush_pend;
        if (bus_ack_i || wd_expired) begin
          bus_req_d = 1'b0;
          bus_err_d = !bus_ack_i;
          if (!flush_pend) if_data_d = bus_ack_i ? bus_rdata_i : '0;
          state_d   = flush_pend ? ARB_DISCARD : ARB_INST_DONE;
        end
      end
      ARB_DATA_DONE, ARB_INST_DONE, ARB_DISCARD: begin
        flushed_d = 1'b0;
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      flushed_q   <= flushed_d;
    end
  end

  always_comb begin
    stallreq_mem_o = mem_ce_i &&
                     ((state_q == ARB_IDLE && !flush_i) || state_q == ARB_DATA_BUSY);
    stallreq_if_o  = if_ce_i &&
                     ((state_q == ARB_IDLE && !flush_i) || state_q == ARB_DATA_BUSY ||
                      state_q == ARB_DATA_DONE || state_q == ARB_INST_BUSY ||
                      state_q == ARB_DISCARD);
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, compared
// every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, if_ce_i, mem_ce_i, mem_we_i, bus_ack_i;
  logic [DW-1:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [3:0]    mem_sel_i;
  logic [DW-1:0] if_data_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic          stallreq_if_o, stallreq_mem_o, bus_req_o, bus_we_o, bus_err_o;
  logic [3:0]    bus_sel_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .stallreq_if_o(stallreq_if_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );

  int checks = 0;
  int errors = 0;
  int n_sif, n_smem, n_req, n_err;

  // Transaction-level model: one outstanding access, its owner, its age in
  // busy cycles, whether it was flushed, and a one-cycle post phase
  // (0 none, 1 data done, 2 fetch done, 3 discarded fetch).
  bit          m_busy, m_data, m_drop;
  int          m_age, m_post;
  logic        m_req, m_we, m_err;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_ifd, m_memd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_drop = 0; m_age = 0; m_post = 0;
    m_req = 0; m_we = 0; m_err = 0; m_sel = 0;
    m_addr = 0; m_wdata = 0; m_ifd = 0; m_memd = 0;
  endtask

  task automatic compare();
    bit   idle;
    logic e_smem, e_sif;
    idle   = !m_busy && (m_post == 0);
    e_smem = mem_ce_i && ((idle && !flush_i) || (m_busy && m_data));
    e_sif  = if_ce_i && ((idle && !flush_i) || m_busy || m_post == 1 || m_post == 3);
    chk("stallreq_mem", stallreq_mem_o, e_smem);
    chk("stallreq_if", stallreq_if_o, e_sif);
    chk("bus_req", bus_req_o, m_req);
    chk("bus_err", bus_err_o, m_err);
    chk("if_data", if_data_o, m_ifd);
    chk("mem_rdata", mem_rdata_o, m_memd);
    if (m_req) begin
      chk("bus_we", bus_we_o, m_we);
      chk("bus_sel", bus_sel_o, m_sel);
      chk("bus_addr", bus_addr_o, m_addr);
      if (m_we) chk("bus_wdata", bus_wdata_o, m_wdata);
    end
  endtask

  task automatic model_step();
    bit dpend;
    m_err = 0;
    if (m_post != 0) begin
      m_post = 0;
    end else if (m_busy) begin
      dpend = m_drop || (!m_data && flush_i);
      if (bus_ack_i || (m_age + 1 == TO)) begin
        m_busy = 0; m_req = 0; m_err = !bus_ack_i;
        if (m_data) begin
          if (!bus_ack_i) m_memd = 0;
          else if (!m_we) m_memd = bus_rdata_i;
          m_post = 1;
        end else begin
          if (!dpend) m_ifd = bus_ack_i ? bus_rdata_i : 32'h0;
          m_post = dpend ? 3 : 2;
        end
      end else begin
        m_age++;
        m_drop = dpend;
      end
    end else if (!flush_i) begin
      if (mem_ce_i) begin
        m_busy = 1; m_data = 1; m_drop = 0; m_age = 0; m_req = 1;
        m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
      end else if (if_ce_i) begin
        m_busy = 1; m_data = 0; m_drop = 0; m_age = 0; m_req = 1;
        m_we = 0; m_sel = 4'hF; m_addr = if_addr_i; m_wdata = 0;
      end
    end
  endtask

  task automatic step(input logic fl, input logic ic, input logic [31:0] ia,
                      input logic mc, input logic mw, input logic [3:0] ms,
                      input logic [31:0] ma, input logic [31:0] md,
                      input logic ak, input logic [31:0] rd);
    @(negedge clk);
    flush_i = fl; if_ce_i = ic; if_addr_i = ia;
    mem_ce_i = mc; mem_we_i = mw; mem_sel_i = ms; mem_addr_i = ma; mem_wdata_i = md;
    bus_ack_i = ak; bus_rdata_i = rd;
    #1;
    compare();
    n_sif  += int'(stallreq_if_o);
    n_smem += int'(stallreq_mem_o);
    n_req  += int'(bus_req_o);
    n_err  += int'(bus_err_o);
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clr_counts();
    n_sif = 0; n_smem = 0; n_req = 0; n_err = 0;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req_o, 0);
    chk({tag, "_bus_we"}, bus_we_o, 0);
    chk({tag, "_bus_sel"}, bus_sel_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
    chk({tag, "_bus_err"}, bus_err_o, 0);
    chk({tag, "_if_data"}, if_data_o, 0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 0);
    chk({tag, "_stall_if"}, stallreq_if_o, 0);
    chk({tag, "_stall_mem"}, stallreq_mem_o, 0);
  endtask

  initial begin
    flush_i = 0; if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0;
    mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    model_reset();
    clr_counts();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fetch only, ack in first request cycle
    clr_counts();
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h3C010001);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_stall_if_cycles", n_sif, 2);
    chk("fetch_req_cycles", n_req, 1);
    chk("fetch_if_data", if_data_o, 32'h3C010001);

    // Data and fetch together: data first with two wait states, then fetch
    clr_counts();
    step(0, 1, 32'h44, 1, 0, 4'hF, 32'h80, 0, 0, 0);
    step(0, 1, 32'h44, 1, 0, 4'hF, 32'h80, 0, 0, 0);
    step(0, 1, 32'h44, 1, 0, 4'hF, 32'h80, 0, 0, 0);
    step(0, 1, 32'h44, 1, 0, 4'hF, 32'h80, 0, 1, 32'hDEADBEEF);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    chk("both_fetch_addr", bus_addr_o, 32'h44);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 1, 32'h24020005);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    chk("both_stall_mem_cycles", n_smem, 4);
    chk("both_stall_if_cycles", n_sif, 7);
    chk("both_mem_rdata", mem_rdata_o, 32'hDEADBEEF);
    chk("both_if_data", if_data_o, 32'h24020005);

    // Store: lanes and data held until ack, load register untouched
    step(0, 0, 0, 1, 1, 4'b0011, 32'h100, 32'h0000BEEF, 0, 0);
    chk("store_we", bus_we_o, 1);
    chk("store_sel", bus_sel_o, 4'b0011);
    chk("store_wdata", bus_wdata_o, 32'h0000BEEF);
    step(0, 0, 0, 1, 1, 4'b0011, 32'h100, 32'h0000BEEF, 0, 0);
    chk("store_sel_held", bus_sel_o, 4'b0011);
    chk("store_wdata_held", bus_wdata_o, 32'h0000BEEF);
    step(0, 0, 0, 1, 1, 4'b0011, 32'h100, 32'h0000BEEF, 1, 32'hFFFFFFFF);
    chk("store_req_drop", bus_req_o, 0);
    chk("store_mem_rdata", mem_rdata_o, 32'hDEADBEEF);
    idle_step();

    // Flush during fetch: completes, result discarded
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h12345678);
    chk("discard_if_data", if_data_o, 32'h24020005);
    clr_counts();
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    chk("discard_stall_if", n_sif, 1);
    idle_step();
    chk("discard_back_idle", bus_req_o, 0);

    // Watchdog abort of a load
    clr_counts();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0);
    chk("timeout_err", bus_err_o, 1);
    chk("timeout_mem_rdata", mem_rdata_o, 0);
    chk("timeout_req", bus_req_o, 0);
    chk("timeout_req_cycles", n_req, 4);
    step(0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0);
    chk("timeout_err_pulse", bus_err_o, 0);
    chk("timeout_stall_mem_cycles", n_smem, 5);
    idle_step();
    chk("timeout_err_count", n_err, 1);

    // Asynchronous reset in the middle of a data access
    step(0, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0);
    @(negedge clk);
    mem_ce_i = 0; if_ce_i = 0; flush_i = 0; bus_ack_i = 0;
    rst = 1'b0;
    #1 chk_all_zero("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    chk("postreset_req", bus_req_o, 1);
    chk("postreset_addr", bus_addr_o, 32'h44);
    chk("postreset_sel", bus_sel_o, 4'hF);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    idle_step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic fl, ic, mc, mw, ak;
      fl = ($urandom % 8) == 0;
      ic = ($urandom % 2) == 0;
      mc = ($urandom % 3) == 0;
      mw = ($urandom % 2) == 0;
      ak = m_busy ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      step(fl, ic, $urandom, mc, mw, 4'($urandom), $urandom, $urandom, ak, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
